// File: rtl/ddr_rd_capture.sv
// DDR4 read-return capture: times each CAS_R by read latency, packs one burst of dq beats
// and returns it with its tag over valid/ready. DDR_RD_CAPTURE_XCHECK_EN enables X/Z beat checking.
module ddr_rd_capture #(
  parameter int DATA_WIDTH      = 8,
  parameter int BURST_LENGTH    = 8,
  parameter int READ_LATENCY    = 11,
  parameter int PREAMBLE        = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_WIDTH       = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               rd_issue,
  input  logic [TAG_WIDTH-1:0]               rd_tag,
  input  logic [DATA_WIDTH-1:0]              dq,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [DATA_WIDTH*BURST_LENGTH-1:0] rdata,
  output logic [TAG_WIDTH-1:0]               rtag,
  output logic                               busy,
  output logic [3:0]                         err_flags,
  input  logic                               err_clr
);
  localparam int RL = READ_LATENCY + PREAMBLE;
  localparam int CW = $clog2(RL + BURST_LENGTH) + 2;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = $clog2(BURST_LENGTH + 1);
  localparam int WW = DATA_WIDTH * BURST_LENGTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  logic [CW-1:0]        cnt;
  logic [TAG_WIDTH-1:0] q_tag [MAX_OUTSTANDING];
  logic [CW-1:0]        q_ts  [MAX_OUTSTANDING];
  logic [AW-1:0]        q_wp, q_rp;
  logic [AW:0]          q_cnt;
  logic                 head_mature, push, err_full;

  state_t               state, state_nxt;
  logic                 start, sample, overlap, ob_wr;
  logic [BW-1:0]        beat_cnt;
  logic [WW-1:0]        word;
  logic [TAG_WIDTH-1:0] cur_tag;

  logic [WW-1:0]        ob_data [2];
  logic [TAG_WIDTH-1:0] ob_tag  [2];
  logic                 ob_rp, ob_wp, ob_pop, ob_acc, err_ovf;
  logic [1:0]           ob_cnt;
  logic                 x_err;

  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else       cnt <= cnt + 1'b1;

  // Every entry matures exactly RL clocks after its push, so only the head can match.
  assign head_mature = (q_cnt != '0) && ((cnt - q_ts[q_rp]) == CW'(RL));
  assign push        = rd_issue && ((q_cnt != (AW+1)'(MAX_OUTSTANDING)) || head_mature);
  assign err_full    = rd_issue && !push;

  always_ff @(posedge clock)
    if (push) begin
      q_tag[q_wp] <= rd_tag;
      q_ts[q_wp]  <= cnt;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (push)        q_wp <= (q_wp == AW'(MAX_OUTSTANDING-1)) ? '0 : q_wp + 1'b1;
      if (head_mature) q_rp <= (q_rp == AW'(MAX_OUTSTANDING-1)) ? '0 : q_rp + 1'b1;
      q_cnt <= q_cnt + (AW+1)'(push) - (AW+1)'(head_mature);
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    overlap   = 1'b0;
    ob_wr     = 1'b0;
    case (state)
      IDLE: if (head_mature) begin
        start     = 1'b1;
        state_nxt = (BURST_LENGTH == 1) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        sample  = 1'b1;
        overlap = head_mature;
        if (beat_cnt == BW'(BURST_LENGTH-1)) state_nxt = DONE;
      end
      DONE: begin
        ob_wr = 1'b1;
        if (head_mature) begin
          start     = 1'b1;
          state_nxt = (BURST_LENGTH == 1) ? DONE : CAPTURE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      word     <= '0;
      beat_cnt <= '0;
      cur_tag  <= '0;
    end else if (start) begin
      word     <= WW'(dq);
      beat_cnt <= BW'(1);
      cur_tag  <= q_tag[q_rp];
    end else if (sample) begin
      word[beat_cnt*DATA_WIDTH +: DATA_WIDTH] <= dq;
      beat_cnt <= beat_cnt + 1'b1;
    end

  // Output skid buffer: a same-cycle pop frees the slot for the incoming burst.
  assign ob_pop  = rvalid && rready;
  assign ob_acc  = ob_wr && ((ob_cnt != 2'd2) || ob_pop);
  assign err_ovf = ob_wr && !ob_acc;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ob_data[0] <= '0;
      ob_data[1] <= '0;
      ob_tag[0]  <= '0;
      ob_tag[1]  <= '0;
      ob_rp      <= 1'b0;
      ob_wp      <= 1'b0;
      ob_cnt     <= '0;
    end else begin
      if (ob_acc) begin
        ob_data[ob_wp] <= word;
        ob_tag[ob_wp]  <= cur_tag;
        ob_wp          <= ~ob_wp;
      end
      if (ob_pop) ob_rp <= ~ob_rp;
      ob_cnt <= ob_cnt + 2'(ob_acc) - 2'(ob_pop);
    end

  assign rvalid = (ob_cnt != '0);
  assign rdata  = ob_data[ob_rp];
  assign rtag   = ob_tag[ob_rp];
  assign busy   = (q_cnt != '0) || (state != IDLE) || (ob_cnt != '0);

`ifdef DDR_RD_CAPTURE_XCHECK_EN
  assign x_err = (start || sample) && $isunknown(dq);
  always_ff @(posedge clock)
    if (!reset && x_err)
      $error("ddr_rd_capture: X/Z beat tag=%0h beat=%0d",
             start ? q_tag[q_rp] : cur_tag, start ? 0 : int'(beat_cnt));
`else
  assign x_err = 1'b0;
`endif

  // A flag raised in the same cycle as err_clr survives the clear.
  always_ff @(posedge clock or posedge reset)
    if (reset) err_flags <= '0;
    else       err_flags <= (err_clr ? 4'b0 : err_flags) | {x_err, err_ovf, overlap, err_full};

endmodule

// File: tb/tb_ddr_rd_capture.sv
// Directed + random bench for ddr_rd_capture against a queue-based model of issue/return timing.
module tb_ddr_rd_capture;
  localparam int DW = 8, BL = 8, RL = 12, MAXO = 4, TW = 4, WW = DW*BL;

  logic clock = 1'b0, reset = 1'b1, rd_issue = 1'b0, rready = 1'b1, err_clr = 1'b0;
  logic [TW-1:0] rd_tag = '0;
  logic [DW-1:0] dq = '0;
  logic          rvalid, busy;
  logic [WW-1:0] rdata;
  logic [TW-1:0] rtag;
  logic [3:0]    err_flags;

  ddr_rd_capture dut (
    .clock(clock), .reset(reset), .rd_issue(rd_issue), .rd_tag(rd_tag), .dq(dq),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rtag(rtag), .busy(busy),
    .err_flags(err_flags), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] hist [0:8191];
  int            pend_t [$];
  logic [TW-1:0] pend_g [$];
  logic [WW-1:0] oq_d [$];
  logic [TW-1:0] oq_t [$];
  bit            cap_act = 0;
  int            cap_start = 0;
  logic [TW-1:0] cap_tag = '0;
  logic [3:0]    m_err = '0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend_t.delete(); pend_g.delete(); oq_d.delete(); oq_t.delete();
    cap_act = 0; m_err = '0;
  endtask

  // Advance the model across the coming edge using the inputs presented to it.
  task automatic model_edge();
    int e;
    bit pop_o, wr, inc, mat;
    logic [3:0] s;
    logic [TW-1:0] mtag;
    logic [WW-1:0] w;
    e = cyc + 1;
    s = '0;
    mtag = '0;
    hist[e] = dq;
    pop_o = (oq_d.size() > 0) && rready;
    wr    = cap_act && (e == cap_start + BL);
    inc   = cap_act && (e < cap_start + BL);
    mat   = (pend_t.size() > 0) && (pend_t[0] + RL == e);
    if (mat) begin
      mtag = pend_g.pop_front();
      void'(pend_t.pop_front());
    end
    if (rd_issue) begin
      if (pend_t.size() < MAXO) begin
        pend_t.push_back(e);
        pend_g.push_back(rd_tag);
      end else s[0] = 1'b1;
    end
    if (pop_o) begin
      void'(oq_d.pop_front());
      void'(oq_t.pop_front());
    end
    if (wr) begin
      for (int i = 0; i < BL; i++) w[i*DW +: DW] = hist[cap_start + i];
      if (oq_d.size() < 2) begin
        oq_d.push_back(w);
        oq_t.push_back(cap_tag);
      end else s[2] = 1'b1;
      cap_act = 0;
    end
    if (mat) begin
      if (inc) s[1] = 1'b1;
      else begin
        cap_act = 1; cap_start = e; cap_tag = mtag;
      end
    end
    m_err = (err_clr ? 4'b0 : m_err) | s;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    chk("rvalid", WW'(rvalid), WW'(oq_d.size() > 0));
    if (oq_d.size() > 0) begin
      chk("rdata", rdata, oq_d[0]);
      chk("rtag", WW'(rtag), WW'(oq_t[0]));
    end
    chk("busy", WW'(busy), WW'((pend_t.size() > 0) || cap_act || (oq_d.size() > 0)));
    chk("err_flags", WW'(err_flags), WW'(m_err));
    dq = DW'($urandom);
  endtask

  task automatic idle(input int n);
    rd_issue = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic [TW-1:0] t);
    rd_issue = 1'b1; rd_tag = t;
    step();
    rd_issue = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rvalid"}, WW'(rvalid), '0);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_rtag"}, WW'(rtag), '0);
    chk({tag, "_busy"}, WW'(busy), '0);
    chk({tag, "_err"}, WW'(err_flags), '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_zero("reset");
    model_clear();
    repeat (2) begin @(posedge clock); cyc++; end
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    repeat (2) begin @(posedge clock); cyc++; end
    @(negedge clock);
    check_zero("por");
    reset = 1'b0;
    idle(4);

    // single read with a known beat pattern
    issue(4'd3);
    idle(RL - 1);
    for (int i = 0; i < BL; i++) begin
      v = DW'(17 * (i + 1));
      dq = v;
      step();
    end
    chk("single_rvalid_early", WW'(rvalid), '0);
    step();
    chk("single_data", rdata, 64'h8877665544332211);
    chk("single_tag", WW'(rtag), WW'(4'd3));
    idle(4);

    // back-to-back at exact burst spacing
    issue(4'd1); idle(BL - 1); issue(4'd2);
    idle(RL + 2*BL + 4);
    chk("b2b_err", WW'(err_flags), '0);

    // overlap: second CAS_R only 4 clocks later
    issue(4'd5); idle(3); issue(4'd6);
    idle(RL + 2*BL + 4);
    chk("overlap_err1", WW'(err_flags[1]), WW'(1'b1));
    clr();

    // queue full: 5 issues before the first one matures
    for (int i = 0; i < 5; i++) begin issue(TW'(8 + i)); idle(1); end
    chk("full_err0", WW'(err_flags[0]), WW'(1'b1));
    idle(RL + 2*BL + 8);
    clr();

    // backpressure over three bursts
    rready = 1'b0;
    issue(4'd7); idle(BL - 1); issue(4'd8); idle(BL - 1); issue(4'd9);
    idle(RL + BL + 4);
    chk("bp_err2", WW'(err_flags[2]), WW'(1'b1));
    chk("bp_hold_tag", WW'(rtag), WW'(4'd7));
    rready = 1'b1;
    idle(6);
    chk("bp_drained", WW'(rvalid), '0);
    clr();

    // reset just before beat 4
    issue(4'd10);
    idle(RL + 3);
    do_reset();
    idle(30);
    issue(4'd11);
    idle(RL + BL + 5);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      rd_issue = ($urandom_range(0, 5) == 0);
      rd_tag   = TW'($urandom);
      rready   = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 40) == 0);
      step();
    end
    rd_issue = 1'b0; err_clr = 1'b0; rready = 1'b1;
    idle(RL + 2*BL + 6);
    chk("final_idle", WW'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
